// File: rtl/scroll_display_ctrl.sv
// -----------------------------------------------------------------------------
// scroll_display_ctrl
//
// Multi-digit 7-segment message scroller. A writable buffer of MSG_DEPTH
// segment codes is viewed through an N_DIGITS-wide window. The window start
// pointer rotates left or right at a prescaled rate, either continuously
// (wrap) or for exactly one full pass of the message (one-shot).
//
// Ports:
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   start    : pulse, launch/restart scrolling (captures dir/oneshot/div/msg_len)
//   stop     : pulse, abort to IDLE (wins over start)
//   dir      : 0 = scroll left (ptr increments), 1 = scroll right (ptr decrements)
//   oneshot  : 1 = finish after one full pass
//   div      : shift every div+1 cycles
//   msg_len  : active message length (0 -> 1, >MSG_DEPTH -> MSG_DEPTH)
//   wr_en    : buffer write strobe
//   wr_addr  : buffer write address (addresses >= MSG_DEPTH ignored)
//   wr_data  : segment code to write
//   seg_out  : registered window, digit i = seg_out[i*SEG_W +: SEG_W]
//   busy     : high while scrolling
//   done     : high after a completed one-shot pass
//   step     : one-cycle pulse, coincident with each pointer update
// -----------------------------------------------------------------------------
module scroll_display_ctrl #(
  parameter int N_DIGITS   = 8,
  parameter int MSG_DEPTH  = 16,
  parameter int SEG_W      = 8,
  parameter int PRESCALE_W = 16,
  parameter int AW         = $clog2(MSG_DEPTH),
  parameter int LW         = $clog2(MSG_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      dir,
  input  logic                      oneshot,
  input  logic [PRESCALE_W-1:0]     div,
  input  logic [LW-1:0]             msg_len,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [SEG_W-1:0]          wr_data,
  output logic [N_DIGITS*SEG_W-1:0] seg_out,
  output logic                      busy,
  output logic                      done,
  output logic                      step
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [LW-1:0]    LEN_MAX = LW'(MSG_DEPTH);
  localparam logic [SEG_W-1:0] BLANK   = '1;

  state_t                      state_q, state_d;
  logic [LW-1:0]               ptr_q, ptr_d;
  logic [PRESCALE_W-1:0]       cnt_q, cnt_d;
  logic [LW-1:0]               steps_q, steps_d;
  logic [LW-1:0]               len_q, len_d;
  logic [PRESCALE_W-1:0]       div_q, div_d;
  logic                        dir_q, dir_d;
  logic                        oneshot_q, oneshot_d;
  logic                        step_q, step_d;
  logic [SEG_W-1:0]            mem_q [MSG_DEPTH];
  logic [SEG_W-1:0]            mem_d [MSG_DEPTH];
  logic [N_DIGITS*SEG_W-1:0]   seg_q, seg_d;
  logic [LW-1:0]               win_idx;

  logic                        launch;
  logic                        tick;
  logic                        last_shift;

  // Captured length is always in 1..MSG_DEPTH so the pointer arithmetic
  // below never needs a real divider.
  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    if (l == '0) begin
      return LW'(1);
    end else if (l > LEN_MAX) begin
      return LEN_MAX;
    end else begin
      return l;
    end
  endfunction

  function automatic logic [LW-1:0] ptr_next(input logic [LW-1:0] p,
                                             input logic [LW-1:0] len,
                                             input logic          d);
    logic [LW-1:0] inc;
    inc = p + LW'(1);
    if (!d) begin
      return (inc == len) ? '0 : inc;
    end else begin
      return (p == '0) ? len - LW'(1) : p - LW'(1);
    end
  endfunction

  // start relaunches from any state; stop always has priority.
  assign launch     = start & ~stop;
  assign tick       = (state_q == S_RUN) & ~stop & ~start & (cnt_q == div_q);
  assign last_shift = tick & oneshot_q & ((steps_q + LW'(1)) == len_q);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else if (start) begin
      state_d = S_RUN;
    end else if (last_shift) begin
      state_d = S_DONE;
    end
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control datapath: capture, prescaler, pointer, pass counter
  // ---------------------------------------------------------------------------
  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    steps_d   = steps_q;
    len_d     = len_q;
    div_d     = div_q;
    dir_d     = dir_q;
    oneshot_d = oneshot_q;
    step_d    = tick;

    if (launch) begin
      dir_d     = dir;
      oneshot_d = oneshot;
      div_d     = div;
      len_d     = clamp_len(msg_len);
      ptr_d     = '0;
      cnt_d     = '0;
      steps_d   = '0;
    end else if ((state_q == S_RUN) && !stop) begin
      if (tick) begin
        cnt_d = '0;
        ptr_d = ptr_next(ptr_q, len_q, dir_q);
        // Only one-shot passes are counted, so wrap mode can run forever.
        if (oneshot_q) begin
          steps_d = last_shift ? '0 : steps_q + LW'(1);
        end
      end else begin
        cnt_d = cnt_q + PRESCALE_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Message buffer write port and window read
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_d = mem_q;
    if (wr_en && (int'(wr_addr) < MSG_DEPTH)) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // The window index walks from ptr and wraps at len_q; since ptr < len_q
  // this is an exact modulo even when the message is shorter than the
  // display, in which case the message simply repeats across the digits.
  // Reads use mem_q, so a same-cycle write shows on the following update.
  always_comb begin
    seg_d   = '1;
    win_idx = ptr_q;
    for (int i = 0; i < N_DIGITS; i++) begin
      seg_d[i*SEG_W +: SEG_W] = mem_q[win_idx[AW-1:0]];
      win_idx = ((win_idx + LW'(1)) == len_q) ? '0 : win_idx + LW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      cnt_q     <= '0;
      steps_q   <= '0;
      len_q     <= LEN_MAX;
      div_q     <= '0;
      dir_q     <= 1'b0;
      oneshot_q <= 1'b0;
      step_q    <= 1'b0;
      seg_q     <= '1;
      for (int i = 0; i < MSG_DEPTH; i++) begin
        mem_q[i] <= BLANK;
      end
    end else begin
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      steps_q   <= steps_d;
      len_q     <= len_d;
      div_q     <= div_d;
      dir_q     <= dir_d;
      oneshot_q <= oneshot_d;
      step_q    <= step_d;
      seg_q     <= seg_d;
      for (int i = 0; i < MSG_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign seg_out = seg_q;
  assign step    = step_q;

endmodule
